// File: rtl/mmio_bank.sv
// mmio_bank: memory-mapped register bank for board buttons and display controls.
// Each button channel goes through a 2-flop synchroniser, an optional debouncer
// and a rising-edge detector that sets a sticky, write-1-to-clear flag.
// N_REG writable control registers are exported as a flat bus on ctrl.
// Addresses outside the window return the RAM read data unchanged.
// Build option: define MMIO_DEBOUNCE_EN to include the debouncer. When it is
// undefined, btn_level is taken straight from the synchroniser and DEB_CYCLES
// has no effect.
module mmio_bank #(
  parameter int BASE       = 1000,
  parameter int ADDR_W     = 12,
  parameter int N_BTN      = 3,
  parameter int N_REG      = 4,
  parameter int REG_W      = 8,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wEn,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [31:0]              dataIn,
  input  logic [31:0]              ram_dataOut,
  input  logic [N_BTN-1:0]         btn,
  output logic [31:0]              dataOut,
  output logic [N_REG*REG_W-1:0]   ctrl,
  output logic [N_BTN-1:0]         btn_level,
  output logic [N_BTN-1:0]         btn_pulse
);

  // One extra bit lets addresses below BASE wrap to a large offset.
  localparam int OFF_W = ADDR_W + 1;
  localparam logic [OFF_W-1:0] BASE_X   = OFF_W'(BASE);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(N_REG + 1);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [OFF_W-1:0] off;
  logic             in_win;
  logic             sel_lvl;
  logic             sel_flag;
  logic [N_REG-1:0] sel_reg;

  assign off      = {1'b0, addr} - BASE_X;
  assign in_win   = (off <= OFF_LAST);
  assign sel_lvl  = in_win && (off == OFF_W'(0));
  assign sel_flag = in_win && (off == OFF_W'(1));

  // Select line for each control register.
  always_comb begin
    sel_reg = '0;
    for (int i = 0; i < N_REG; i++) begin
      sel_reg[i] = in_win && (off == OFF_W'(i + 2));
    end
  end

  // ---------------------------------------------------------------------------
  // Button path: synchroniser -> (debouncer) -> edge detector
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] sync_p0;
  logic [N_BTN-1:0] sync_p1;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] level_d;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] pulse_p3;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

`ifdef MMIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  // Count that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt_p2 [N_BTN];

  // The level follows the synchronised input only after it has differed for
  // DEB_CYCLES consecutive cycles. Any agreement restarts the count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_BTN; i++) begin
      if (reset) begin
        cnt_p2[i] <= '0;
        level[i]  <= 1'b0;
      end else if (sync_p1[i] == level[i]) begin
        cnt_p2[i] <= '0;
      end else if (cnt_p2[i] == CNT_LAST) begin
        level[i]  <= sync_p1[i];
        cnt_p2[i] <= '0;
      end else begin
        cnt_p2[i] <= sat_inc(cnt_p2[i]);
      end
    end
  end
`else
  localparam int unused_deb_cycles = DEB_CYCLES;

  assign level = sync_p1;
`endif

  assign rise = level & ~level_d;

  // Previous level and the registered one-cycle rising-edge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_d  <= '0;
      pulse_p3 <= '0;
    end else begin
      level_d  <= level;
      pulse_p3 <= rise;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky edge flags with write-1-to-clear
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] flags;
  logic [N_BTN-1:0] clr;

  assign clr = (wEn && sel_flag) ? dataIn[N_BTN-1:0] : '0;

  // Setting has priority: a clear landing with an edge (the edge that launches
  // the pulse, or the cycle the pulse is high) leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
    end else begin
      flags <= (flags & ~clr) | rise | pulse_p3;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  logic [REG_W-1:0] regs [N_REG];

  // Each register takes the low REG_W bits of the write data.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REG; i++) begin
      if (reset) begin
        regs[i] <= '0;
      end else if (wEn && sel_reg[i]) begin
        regs[i] <= dataIn[REG_W-1:0];
      end
    end
  end

  // Flatten the registers onto the display control bus.
  always_comb begin
    ctrl = '0;
    for (int i = 0; i < N_REG; i++) begin
      ctrl[i*REG_W +: REG_W] = regs[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  // Zero-latency read: bank contents inside the window, RAM data elsewhere.
  always_comb begin
    dataOut = ram_dataOut;
    if (in_win) begin
      dataOut = '0;
      if (sel_lvl) begin
        dataOut[N_BTN-1:0] = level;
      end else if (sel_flag) begin
        dataOut[N_BTN-1:0] = flags;
      end else begin
        for (int i = 0; i < N_REG; i++) begin
          if (sel_reg[i]) begin
            dataOut[REG_W-1:0] = regs[i];
          end
        end
      end
    end
  end

  assign btn_level = level;
  assign btn_pulse = pulse_p3;

  // Write-data bits above the register and flag widths are not used.
  logic unused_data;
  assign unused_data = ^dataIn;

endmodule
